// File: rtl/day01_pkg.sv
// day01_pkg
// Purpose : shared definitions for the Day 1 puzzle-text parser.
//           The package holds the ASCII codes the parser reacts to,
//           the line-parsing state enumeration, and the default
//           datapath width.
// Ports   : none (package)
package day01_pkg;

    // Default width of the parsed value and of the accumulator
    localparam int DEFAULT_WIDTH = 64;

    // ASCII codes that drive the line grammar
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    // Where we are inside the current text line
    typedef enum logic [1:0] {
        ST_LINE_START = 2'd0,   // nothing seen on this line yet
        ST_SIGNED     = 2'd1,   // a sign was seen, no digit yet
        ST_DIGITS     = 2'd2,   // at least one digit accumulated
        ST_SKIP       = 2'd3    // line is malformed, discard until newline
    } state_e;

endpackage

// File: rtl/day01_parser_ascii_digit.sv
// ascii_digit
// Purpose : combinational classifier that tells whether a byte is an
//           ASCII decimal digit and returns its numeric value.
// Ports   : char_i     - input byte
//           is_digit_o - 1 when char_i is in '0'..'9'
//           value_o    - digit value 0..9 (only meaningful when is_digit_o)
module ascii_digit
    import day01_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       is_digit_o,
    output logic [3:0] value_o
);

    // The digits occupy 0x30..0x39, so the low nibble already is the value
    assign is_digit_o = (char_i >= CH_ZERO) && (char_i <= CH_NINE);
    assign value_o    = char_i[3:0];

endmodule

// File: rtl/day01_parser.sv
// day01_parser
// Purpose : parses a stream of ASCII lines of the form [+|-]digits\n
//           into signed two's-complement values, handing each one
//           downstream through a valid/ready output register.
//           Malformed lines are dropped and flagged by a sticky error.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           in_valid/in_ready  - input byte handshake
//           in_data            - ASCII input byte
//           out_valid/out_ready- output value handshake
//           out_data           - parsed signed value (WIDTH bits)
//           out_count          - saturating count of values handed off
//           error              - sticky malformed-line flag
module day01_parser
    import day01_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   error
);

    state_e                   state_q;
    logic                     neg_q;
    logic [WIDTH-1:0]         acc_q;
    logic [WIDTH-1:0]         outData_q;
    logic                     outValid_q;
    logic [COUNT_WIDTH-1:0]   outCount_q;
    logic                     error_q;

    logic                     isDigit;
    logic [3:0]               digitVal;
    logic [WIDTH-1:0]         digitExt;
    logic [WIDTH-1:0]         accMac_d;
    logic [WIDTH-1:0]         signedAcc_d;
    logic                     inFire;
    logic                     outFire;
    logic                     isSign;
    logic                     isNewline;

    ascii_digit u_digit (
        .char_i     (in_data),
        .is_digit_o (isDigit),
        .value_o    (digitVal)
    );

    // A single output register with no bypass: while a value waits for the
    // downstream side, the input stalls.
    assign in_ready  = ~outValid_q;
    assign inFire    = in_valid & in_ready;
    assign outFire   = outValid_q & out_ready;

    assign isSign    = (in_data == CH_PLUS) || (in_data == CH_MINUS);
    assign isNewline = (in_data == CH_NL);

    // acc*10 + digit built from shifts; everything wraps modulo 2^WIDTH,
    // which is the intended overflow behaviour.
    assign digitExt    = {{(WIDTH-4){1'b0}}, digitVal};
    assign accMac_d    = (acc_q << 3) + (acc_q << 1) + digitExt;
    assign signedAcc_d = neg_q ? -acc_q : acc_q;

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_count = outCount_q;
    assign error     = error_q;

    // Line-parsing FSM plus the output register and its bookkeeping.
    // The output handshake is handled first; an input byte can only be
    // accepted when the output register is empty, so the two never try
    // to change outValid_q in the same cycle. Carriage returns are simply
    // ignored wherever they appear, and every return to ST_LINE_START
    // clears the sign and accumulator so the next line starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LINE_START;
            neg_q      <= 1'b0;
            acc_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outCount_q <= '0;
            error_q    <= 1'b0;
        end else begin
            if (outFire) begin
                outValid_q <= 1'b0;
                if (outCount_q != '1) begin
                    outCount_q <= outCount_q + COUNT_WIDTH'(1);
                end
            end

            if (inFire && (in_data != CH_CR)) begin
                case (state_q)
                    ST_LINE_START: begin
                        if (isSign) begin
                            state_q <= ST_SIGNED;
                            neg_q   <= (in_data == CH_MINUS);
                        end else if (isDigit) begin
                            state_q <= ST_DIGITS;
                            acc_q   <= digitExt;
                        end else if (isNewline) begin
                            neg_q   <= 1'b0;
                            acc_q   <= '0;
                        end else begin
                            state_q <= ST_SKIP;
                            error_q <= 1'b1;
                        end
                    end
                    ST_SIGNED: begin
                        if (isDigit) begin
                            state_q <= ST_DIGITS;
                            acc_q   <= digitExt;
                        end else if (isNewline) begin
                            state_q <= ST_LINE_START;
                            neg_q   <= 1'b0;
                            acc_q   <= '0;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= ST_SKIP;
                            error_q <= 1'b1;
                        end
                    end
                    ST_DIGITS: begin
                        if (isDigit) begin
                            acc_q      <= accMac_d;
                        end else if (isNewline) begin
                            state_q    <= ST_LINE_START;
                            neg_q      <= 1'b0;
                            acc_q      <= '0;
                            outData_q  <= signedAcc_d;
                            outValid_q <= 1'b1;
                        end else begin
                            state_q    <= ST_SKIP;
                            error_q    <= 1'b1;
                        end
                    end
                    ST_SKIP: begin
                        if (isNewline) begin
                            state_q <= ST_LINE_START;
                            neg_q   <= 1'b0;
                            acc_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= ST_LINE_START;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_day01_parser.sv
// tb_day01_parser
// Purpose : self-checking bench for day01_parser. A line-level model
//           (byte queue per line, grammar checked as a whole-string
//           predicate) predicts every output each cycle; directed lines
//           with hand-computed values pin the model, then random lines
//           with random gaps, carriage returns and back-pressure follow.
// Ports   : none (top-level bench)
module tb_day01_parser;

    localparam int W    = 64;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          error;

    int compared = 0;
    int mismatched = 0;

    // Model state
    bit          mValid = 1'b0;
    logic [63:0] mData = '0;
    int          mCount = 0;
    bit          mErr = 1'b0;
    logic [7:0]  lineQ[$];
    logic [63:0] mLog[$];
    bit          mAccepted = 1'b0;
    bit          wasReady = 1'b0;
    bit          checking = 1'b0;
    int          readyMode = 0;

    day01_parser #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .error     (error)
    );

    always #5 clk = ~clk;

    // One comparison: bumps the counters and reports any difference
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit isDigitB(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Can the characters seen so far still become a well-formed line?
    function automatic bit prefixOk();
        for (int i = 0; i < lineQ.size(); i++) begin
            if (!isDigitB(lineQ[i]) &&
                !(i == 0 && (lineQ[i] == 8'h2B || lineQ[i] == 8'h2D)))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit lineComplete();
        return prefixOk() && (lineQ.size() > 0) &&
               !(lineQ.size() == 1 && !isDigitB(lineQ[0]));
    endfunction

    function automatic logic [63:0] lineValue();
        logic [63:0] v;
        bit neg;
        v = '0;
        neg = 1'b0;
        foreach (lineQ[i]) begin
            if (isDigitB(lineQ[i])) v = v * 64'd10 + 64'(lineQ[i] - 8'h30);
            else if (lineQ[i] == 8'h2D) neg = 1'b1;
        end
        return neg ? -v : v;
    endfunction

    task automatic modelByte(input logic [7:0] b);
        if (b == 8'h0D) begin
        end else if (b == 8'h0A) begin
            if (lineQ.size() != 0) begin
                if (lineComplete()) begin
                    mValid = 1'b1;
                    mData  = lineValue();
                end else begin
                    mErr = 1'b1;
                end
            end
            lineQ.delete();
        end else begin
            lineQ.push_back(b);
            if (!prefixOk()) mErr = 1'b1;
        end
    endtask

    // Model advances on each rising edge from the same inputs the DUT sees
    initial forever begin
        @(posedge clk);
        mAccepted = 1'b0;
        if (rst) begin
            mValid = 1'b0;
            mData  = '0;
            mCount = 0;
            mErr   = 1'b0;
            lineQ.delete();
        end else begin
            wasReady = !mValid;
            if (mValid && out_ready) begin
                mLog.push_back(mData);
                mValid = 1'b0;
                if (mCount < CMAX) mCount++;
            end
            if (in_valid && wasReady) begin
                mAccepted = 1'b1;
                modelByte(in_data);
            end
        end
    end

    // Every falling edge: compare all DUT outputs against the model
    initial forever begin
        @(negedge clk);
        if (checking) begin
            checkOutput("in_ready", 64'(in_ready), 64'(!mValid));
            checkOutput("out_valid", 64'(out_valid), 64'(mValid));
            if (mValid) checkOutput("out_data", out_data, mData);
            checkOutput("out_count", 64'(out_count), 64'(mCount));
            checkOutput("error", 64'(error), 64'(mErr));
        end
    end

    // Downstream ready pattern: 0 always ready, 1 random, 2 stalled
    initial forever begin
        @(posedge clk);
        #1;
        case (readyMode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic sendByte(input logic [7:0] b);
        int waitCount;
        in_valid = 1'b1;
        in_data  = b;
        waitCount = 0;
        do begin
            @(posedge clk);
            #1;
            waitCount++;
        end while (!mAccepted && waitCount < 200);
        if (!mAccepted) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL acceptTimeout: byte %0h not taken, required within 200 cycles", b);
        end
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mLog.delete();
        checking = 1'b1;
    endtask

    task automatic checkLog(input string name, input int idx, input logic [63:0] exp);
        logic [63:0] v;
        v = (idx < mLog.size()) ? mLog[idx] : 'x;
        checkOutput(name, v, exp);
    endtask

    task automatic sendRandomLine();
        logic [7:0] bytesQ[$];
        logic [7:0] bad[5];
        int kind;
        int nd;
        bad = '{8'h78, 8'h20, 8'h2B, 8'h2D, 8'h61};
        kind = $urandom_range(0, 9);
        if (kind != 0 && $urandom_range(0, 1) == 1)
            bytesQ.push_back(($urandom_range(0, 1) == 1) ? 8'h2D : 8'h2B);
        if (kind == 1 && bytesQ.size() == 0) bytesQ.push_back(8'h2D);
        if (kind >= 2) begin
            nd = $urandom_range(1, 20);
            for (int i = 0; i < nd; i++) bytesQ.push_back(8'(8'h30 + $urandom_range(0, 9)));
        end
        if (kind == 2) begin
            bytesQ.push_back(bad[$urandom_range(0, 4)]);
            bytesQ.push_back(8'h35);
        end
        bytesQ.push_back(8'h0A);
        foreach (bytesQ[i]) begin
            if ($urandom_range(0, 9) == 0) sendByte(8'h0D);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            sendByte(bytesQ[i]);
        end
    endtask

    initial begin
        doReset();

        $display("[TB] two signed lines");
        applyStimulus("+12\n-3\n");
        idle(3);
        checkOutput("t1_count", 64'(out_count), 64'd2);
        checkOutput("t1_error", 64'(error), 64'd0);
        checkLog("t1_val0", 0, 64'd12);
        checkLog("t1_val1", 1, -64'sd3);

        $display("[TB] back-pressure hold");
        doReset();
        readyMode = 2;
        out_ready = 1'b0;
        applyStimulus("+7\n");
        idle(5);
        checkOutput("t2_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_data", out_data, 64'd7);
        checkOutput("t2_in_ready", 64'(in_ready), 64'd0);
        readyMode = 0;
        idle(3);
        checkOutput("t2_count", 64'(out_count), 64'd1);
        checkLog("t2_val0", 0, 64'd7);

        $display("[TB] blank lines, CR and sign-only line");
        doReset();
        applyStimulus("\n");
        sendByte(8'h0D);
        applyStimulus("\n-\n+5\n");
        idle(3);
        checkOutput("t3_count", 64'(out_count), 64'd1);
        checkOutput("t3_error", 64'(error), 64'd1);
        checkLog("t3_val0", 0, 64'd5);

        $display("[TB] bad character then good line");
        doReset();
        applyStimulus("+1x2\n+4\n");
        idle(3);
        checkOutput("t4_count", 64'(out_count), 64'd1);
        checkOutput("t4_error", 64'(error), 64'd1);
        checkLog("t4_val0", 0, 64'd4);

        $display("[TB] wrap at 2^64 and most negative value");
        doReset();
        applyStimulus("+18446744073709551616\n-9223372036854775808\n");
        idle(3);
        checkOutput("t5_error", 64'(error), 64'd0);
        checkLog("t5_val0", 0, 64'd0);
        checkLog("t5_val1", 1, 64'h8000000000000000);

        $display("[TB] reset mid-line");
        doReset();
        applyStimulus("+9");
        doReset();
        applyStimulus("+3\n");
        idle(3);
        checkOutput("t6_count", 64'(out_count), 64'd1);
        checkOutput("t6_error", 64'(error), 64'd0);
        checkLog("t6_val0", 0, 64'd3);

        $display("[TB] counter saturation");
        doReset();
        repeat (17) applyStimulus("1\n");
        idle(3);
        checkOutput("t7_count", 64'(out_count), 64'(CMAX));
        checkOutput("t7_logsize", 64'(mLog.size()), 64'd17);

        $display("[TB] random lines");
        doReset();
        readyMode = 1;
        for (int n = 0; n < 200; n++) begin
            sendRandomLine();
            if (n == 100) begin
                readyMode = 2;
                idle($urandom_range(2, 8));
                readyMode = 1;
            end
        end
        readyMode = 0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/day01_parser.md
DAY01_PARSER -- requirements
Module: day01_parser

Interface
REQ-001 Parameter WIDTH, default 64: width of signed output value and accumulator.
REQ-002 Parameter COUNT_WIDTH, default 16: width of emitted-value counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  in_data holds a valid ASCII byte.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  8  ASCII input byte (puzzle text stream).
REQ-008 out_valid  output  1  out_data holds a parsed value.
REQ-009 out_ready  input  1  downstream summer consumes out_data this cycle.
REQ-010 out_data  output  WIDTH  signed two's-complement parsed value.
REQ-011 out_count  output  COUNT_WIDTH  number of values handed off downstream.
REQ-012 error  output  1  sticky flag: malformed line seen since reset.

Function
REQ-013 Input byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; output SHALL be transferred only on a cycle with out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL equal NOT out_valid (single output register, no bypass); input stalls while an unconsumed value is held.
REQ-015 Line grammar: optional '+' (0x2B) or '-' (0x2D), then one or more digits '0'-'9' (0x30-0x39), then '\n' (0x0A); '\r' (0x0D) SHALL be discarded in every state with no state change.
REQ-016 FSM states: LINE_START, SIGNED (sign seen, no digit), DIGITS (≥1 digit seen), SKIP (discarding a bad line).
REQ-017 LINE_START: sign -> SIGNED, latch negative flag; digit -> DIGITS, acc = digit; '\n' -> stay (blank line, no output); other byte -> SKIP, set error.
REQ-018 SIGNED: digit -> DIGITS, acc = digit; '\n' -> LINE_START, set error, no output; other byte -> SKIP, set error.
REQ-019 DIGITS: digit -> acc = acc*10 + digit, stay; '\n' -> LINE_START, load out_data = negative ? -acc : acc, set out_valid; other byte -> SKIP, set error.
REQ-020 SKIP: '\n' -> LINE_START, clear negative flag and acc; all other bytes discarded.
REQ-021 acc*10 + digit SHALL be computed modulo 2^WIDTH (wrap, no saturation, no error); negation likewise modulo 2^WIDTH.
REQ-022 out_valid SHALL rise on the cycle after the terminating '\n' is accepted (latency 1) and SHALL hold with out_data stable until the output handshake.
REQ-023 out_count SHALL increment by 1 on each output handshake and SHALL saturate at 2^COUNT_WIDTH-1.
REQ-024 error SHALL stay 1 once set until reset; parsing SHALL continue normally on following lines.
REQ-025 negative flag and acc SHALL clear on every transition to LINE_START.

Reset
REQ-026 While rst=1 at a clock edge: state=LINE_START, acc=0, negative=0, out_valid=0, out_data=0, out_count=0, error=0; in_ready=1 on the cycle after reset release.
REQ-027 Reset mid-line or with out_valid=1 SHALL discard the partial line and the pending value with no handshake counted.

Structure
REQ-028 Shared package day01_pkg SHALL hold the ASCII constants (plus, minus, newline, carriage return, '0', '9), the FSM state enumeration, and the default WIDTH.
REQ-029 One sub-module ascii_digit (combinational: byte -> is_digit, 4-bit value) SHALL be instantiated; the rest stays flat in day01_parser.

Verification
REQ-030 Bytes "+12\n-3\n" with out_ready=1 -> outputs 12 then -3, out_count=2, error=0.
REQ-031 "+7\n" with out_ready held 0 for 5 cycles -> out_valid=1 and out_data=7 stable, in_ready=0 throughout, then one handshake, out_count=1.
REQ-032 "\n\r\n-\n+5\n" -> single output 5; error=1 from "-\n"; out_count=1.
REQ-033 "+1x2\n+4\n" -> no output for first line, error=1, then output 4.
REQ-034 "+18446744073709551616\n" (2^64) -> output 0 (wrap), error=0; "-9223372036854775808\n" -> output 0x8000000000000000.
REQ-035 rst pulsed one cycle after "+9" bytes, then "+3\n" -> output 3 only, out_count=1, error=0.
